// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------
// fnd_pkg : shared glyph table, scan state encoding, blank pattern
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package fnd_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} for hex 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [7:0] seg_encode(input logic [3:0] nib, input logic dp);
    return {~dp, SEG_TABLE[nib]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fnd_slot_timer.sv
// ---------------------------------------------------------------
// fnd_slot_timer : free-running 0..SLOT_CYC-1 counter with wrap pulse
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module fnd_slot_timer #(
  parameter int SLOT_CYC = 10,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(SLOT_CYC - 1);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = (r_count == c_last);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (o_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fnd_scan_controller.sv
// ---------------------------------------------------------------
// fnd_scan_controller : 4-digit multiplexed 7-segment scanner with
// frame-synchronous update; FND_ZERO_BLANK_EN suppresses leading zeros.
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_valid,
  input  logic [15:0] i_wr_data,
  input  logic [3:0]  i_wr_dp,
  output logic        o_wr_ready,
  output logic [3:0]  o_com,
  output logic [7:0]  o_seg,
  output logic        o_frame
);

  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] c_frame_pre  = CNT_W'(SLOT_CYC - 2);

  logic [CNT_W-1:0] w_count;
  logic             w_wrap;

  fnd_slot_timer #(
    .SLOT_CYC (SLOT_CYC),
    .CNT_W    (CNT_W)
  ) u_slot_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_count (w_count),
    .o_wrap  (w_wrap)
  );

  state_t      r_state;
  logic [1:0]  r_idx;
  logic        r_frame;
  logic        r_ready;
  logic [15:0] r_pend_data;
  logic [3:0]  r_pend_dp;
  logic [15:0] r_disp_data;
  logic [3:0]  r_disp_dp;
  logic [3:0]  r_com;
  logic [7:0]  r_seg;

  logic [3:0]  w_nibble;
  logic        w_dp;
  logic        w_zero_blank;
  logic [7:0]  w_seg_drive;
  logic [3:0]  w_com_drive;

  assign w_nibble    = r_disp_data[{r_idx, 2'b00} +: 4];
  assign w_dp        = r_disp_dp[r_idx];
  assign w_com_drive = ~(4'b0001 << r_idx);

`ifdef FND_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_zero_blank = 1'b0;
    case (r_idx)
      2'd3:    w_zero_blank = (r_disp_data[15:12] == 4'h0);
      2'd2:    w_zero_blank = (r_disp_data[15:8]  == 8'h00);
      2'd1:    w_zero_blank = (r_disp_data[15:4]  == 12'h000);
      default: w_zero_blank = 1'b0;
    endcase
  end
`else
  assign w_zero_blank = 1'b0;
`endif

  assign w_seg_drive = w_zero_blank ? {~w_dp, 7'h7F} : seg_encode(w_nibble, w_dp);

  // State and digit index track the count the timer holds next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_BLANK;
      r_idx   <= 2'd0;
      r_frame <= 1'b0;
      r_com   <= 4'b1111;
      r_seg   <= SEG_BLANK;
    end else begin
      case (r_state)
        ST_BLANK: if (!w_wrap && (w_count >= c_blank_last)) r_state <= ST_DRIVE;
        ST_DRIVE: if (w_wrap) r_state <= ST_BLANK;
        default:  r_state <= ST_BLANK;
      endcase
      if (w_wrap) r_idx <= r_idx + 2'd1;
      r_frame <= (w_count == c_frame_pre) && (r_idx == 2'd3);
      if (r_state == ST_DRIVE) begin
        r_com <= w_com_drive;
        r_seg <= w_seg_drive;
      end else begin
        r_com <= 4'b1111;
        r_seg <= SEG_BLANK;
      end
    end
  end

  // Ready is low exactly while an update waits for the frame boundary.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ready     <= 1'b1;
      r_pend_data <= 16'h0000;
      r_pend_dp   <= 4'h0;
      r_disp_data <= 16'h0000;
      r_disp_dp   <= 4'h0;
    end else if (r_frame && !r_ready) begin
      r_disp_data <= r_pend_data;
      r_disp_dp   <= r_pend_dp;
      r_ready     <= 1'b1;
    end else if (i_wr_valid && r_ready) begin
      r_pend_data <= i_wr_data;
      r_pend_dp   <= i_wr_dp;
      r_ready     <= 1'b0;
    end
  end

  assign o_wr_ready = r_ready;
  assign o_com      = r_com;
  assign o_seg      = r_seg;
  assign o_frame    = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
// ---------------------------------------------------------------
// tb_fnd_scan_controller : directed + random scan/update checks
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_fnd_scan_controller;

  logic        clk;
  logic        rst;
  logic        i_wr_valid;
  logic [15:0] i_wr_data;
  logic [3:0]  i_wr_dp;
  logic        o_wr_ready;
  logic [3:0]  o_com;
  logic [7:0]  o_seg;
  logic        o_frame;

  fnd_scan_controller #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .BLANK_CYC (2)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .i_wr_dp    (i_wr_dp),
    .o_wr_ready (o_wr_ready),
    .o_com      (o_com),
    .o_seg      (o_seg),
    .o_frame    (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full active-low glyphs with dp off.
  logic [7:0] GLY [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int checks   = 0;
  int failures = 0;

  // Model: cycle index since reset release, shown and pending values.
  int          m_c;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pend_dp;
  logic        m_ready;
  logic [3:0]  e_com;
  logic [7:0]  e_seg;

`ifdef FND_ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, m_c, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("com",   {4'h0, o_com}, {4'h0, e_com});
    chk("seg",   o_seg, e_seg);
    chk("ready", {7'h0, o_wr_ready}, {7'h0, m_ready});
    chk("frame", {7'h0, o_frame}, {7'h0, (m_c % 40) == 39});
  endtask

  task automatic model_reset();
    m_c = 0; m_disp = 16'h0; m_dp = 4'h0; m_ready = 1'b1;
    m_pend = 16'h0; m_pend_dp = 4'h0;
    e_com = 4'hF; e_seg = 8'hFF;
  endtask

  // Advance one clock: outputs next cycle follow the slot position this cycle.
  task automatic tick();
    int p, d;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        dpb;
    p = m_c % 10;
    d = (m_c / 10) % 4;
    if (p < 2) begin
      e_com = 4'hF;
      e_seg = 8'hFF;
    end else begin
      e_com = ~(4'b0001 << d);
      upper = m_disp >> (4 * d);
      nib   = upper[3:0];
      dpb   = m_dp[d];
      if (ZB && d > 0 && upper == 16'h0) e_seg = 8'hFF;
      else                               e_seg = GLY[nib];
      if (dpb) e_seg[7] = 1'b0;
    end
    if ((m_c % 40) == 39 && !m_ready) begin
      m_disp = m_pend; m_dp = m_pend_dp; m_ready = 1'b1;
    end else if (i_wr_valid && m_ready) begin
      m_pend = i_wr_data; m_pend_dp = i_wr_dp; m_ready = 1'b0;
    end
    @(posedge clk);
    #1;
    m_c++;
    chk_all();
  endtask

  task automatic run_to(input int target);
    while (m_c < target) tick();
  endtask

  task automatic write_once(input logic [15:0] data, input logic [3:0] dp);
    i_wr_valid = 1'b1; i_wr_data = data; i_wr_dp = dp;
    tick();
    i_wr_valid = 1'b0;
  endtask

  initial begin
    i_wr_valid = 1'b0; i_wr_data = 16'h0; i_wr_dp = 4'h0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;
    chk_all();

    // Free run through the first frame.
    run_to(40);

    // Mid-frame write, then an ignored write while busy.
    run_to(55);
    write_once(16'h12AF, 4'b0100);
    chk("ready_drop", {7'h0, o_wr_ready}, 8'h00);
    run_to(60);
    write_once(16'h3333, 4'b1111);
    run_to(80);
    chk("ready_back", {7'h0, o_wr_ready}, 8'h01);
    while (m_c < 119) begin
      tick();
      if (m_c == 85)  chk("dig0_F",  o_seg, 8'h8E);
      if (m_c == 95)  chk("dig1_A",  o_seg, 8'h88);
      if (m_c == 105) chk("dig2_2dp", o_seg, 8'h24);
      if (m_c == 115) chk("dig3_1",  o_seg, 8'hF9);
    end

    // Write on the frame cycle lands one frame later.
    write_once(16'h0070, 4'b0000);
    while (m_c < 200) begin
      if (m_c == 125) chk("old_val_kept", o_seg, 8'h8E);
      if (m_c == 165) chk("z_dig0", o_seg, 8'hC0);
      if (m_c == 175) chk("z_dig1", o_seg, 8'hF8);
      if (m_c == 185) chk("z_dig2", o_seg, ZB ? 8'hFF : 8'hC0);
      if (m_c == 195) chk("z_dig3", o_seg, ZB ? 8'hFF : 8'hC0);
      tick();
    end

    // Reset mid-DRIVE of digit 2 with an update pending.
    run_to(205);
    write_once(16'hBEEF, 4'b1010);
    run_to(225);
    chk("pre_rst_com", {4'h0, o_com}, 8'h0B);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;
    run_to(45);
    chk("post_rst_disp0", o_seg, 8'hC0);

    // Random traffic.
    for (int i = 0; i < 1200; i++) begin
      i_wr_valid = ($urandom_range(0, 7) == 0);
      i_wr_data  = 16'($urandom);
      i_wr_dp    = 4'($urandom);
      tick();
    end
    i_wr_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, SHALL set the i_clk frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, SHALL set the per-digit slot rate in Hz; SLOT_CYC = CLK_HZ/SCAN_HZ cycles per slot.
REQ-003 Parameter BLANK_CYC, default 1000, SHALL set the all-digits-off cycles at the start of each slot; BLANK_CYC < SLOT_CYC.
REQ-004 i_clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 i_wr_valid  input  1  SHALL flag a display update request.
REQ-007 i_wr_data  input  16  SHALL carry four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-008 i_wr_dp  input  4  SHALL carry per-digit decimal-point enables; bit n is digit n.
REQ-009 o_wr_ready  output  1  SHALL be high when an update can be accepted.
REQ-010 o_com  output  4  SHALL be active-low digit commons; at most one bit low at any time.
REQ-011 o_seg  output  8  SHALL be active-low segments {dp,g,f,e,d,c,b,a}.
REQ-012 o_frame  output  1  SHALL pulse high one cycle at the end of the digit-3 slot.

Function
REQ-013 A write SHALL be accepted on a cycle with i_wr_valid && o_wr_ready, latching data and dp into a pending register and dropping o_wr_ready on the next cycle.
REQ-014 Pending contents SHALL be copied to the display register on the o_frame cycle; o_wr_ready SHALL return high the following cycle.
REQ-015 A write accepted on the o_frame cycle itself SHALL be applied at the next frame, not the current one.
REQ-016 The slot counter SHALL count 0..SLOT_CYC-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-017 FSM states BLANK, DRIVE: BLANK for slot counts 0..BLANK_CYC-1, DRIVE for the remainder; BLANK SHALL force o_com=4'b1111 and o_seg=8'hFF.
REQ-018 In DRIVE, o_com SHALL have only bit[index] low and o_seg SHALL show the hex glyph (0-9, A-F) of the display nibble plus dp.
REQ-019 o_com and o_seg SHALL be registered; they change together, one cycle after the state/index change.
REQ-020 i_wr_valid while o_wr_ready is low SHALL be ignored with no side effect.

Reset
REQ-021 On i_reset: o_com=4'b1111, o_seg=8'hFF, o_wr_ready=1, o_frame=0, digit index 0, slot counter 0, state BLANK, display and pending registers 0.
REQ-022 Reset mid-slot or with an update pending SHALL discard the pending update; the scan SHALL restart at digit 0 in BLANK after release.

Configuration
REQ-023 With FND_ZERO_BLANK_EN defined, leading zero digits (digit 3 down to digit 1, stopping at the first nonzero) SHALL drive o_seg=8'hFF except dp if set; digit 0 SHALL always display.
REQ-024 Without FND_ZERO_BLANK_EN, every digit SHALL display its glyph including leading zeros.

Structure
REQ-025 The 16-entry hex-to-segment table, the state encoding, and the blank segment constant SHALL reside in the shared package fnd_pkg.
REQ-026 The slot counter SHALL be the sub-module fnd_slot_timer, providing count value and wrap pulse.

Verification (CLK_HZ=1000, SCAN_HZ=100, BLANK_CYC=2 -> SLOT_CYC=10)
REQ-027 Reset then free-run 40 cycles -> o_com sequence 1110,1101,1011,0111, each low 8 cycles after 2 all-high cycles; o_frame pulses at cycle 39.
REQ-028 Write 16'h12AF, dp=4'b0100, mid-frame -> o_wr_ready low until next o_frame+1; next frame shows F(8'h8E), A(8'h88), 2 with dp(8'h24), 1(8'hF9).
REQ-029 Second write while o_wr_ready low -> ignored; display keeps first value.
REQ-030 Write on the o_frame cycle -> applied one frame later.
REQ-031 FND_ZERO_BLANK_EN, write 16'h0070 -> digits 3,2 8'hFF, digit 1 7(8'hF8), digit 0 0(8'hC0); without macro digits 3,2 show 8'hC0.
REQ-032 i_reset asserted mid-DRIVE of digit 2 with a pending write -> outputs blank immediately; after release digit 0 scans first, display 0, o_wr_ready=1.
